// File: rtl/apb_pkg.sv
// Shared APB4 types: the protection field and the arbiter's transfer-phase state.
package apb_pkg;

    typedef logic [2:0] prot_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cf_math_pkg.sv
// Small math helpers shared by parametrised blocks.
// idx_width() gives the bit width needed to index num_idx items, never less than 1.
package cf_math_pkg;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin search: first set request at index >= rr_i, wrapping.
// Returns the winning index and whether any request was present.
module apb_rr_pick #(
    parameter int unsigned NoReq = 2,
    localparam int unsigned IdxW = cf_math_pkg::idx_width(NoReq),
    localparam int unsigned ExtW = 1 << IdxW
) (
    input  logic [NoReq-1:0] req_i,
    input  logic [IdxW-1:0]  rr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    logic [ExtW-1:0] reqExt;
    logic [IdxW:0]   cand;

    // One spare bit in cand holds rr_i + k before folding it back below NoReq.
    always_comb begin
        reqExt             = '0;
        reqExt[NoReq-1:0]  = req_i;
        cand               = '0;
        idx_o              = '0;
        valid_o            = 1'b0;
        for (int unsigned k = 0; k < NoReq; k++) begin
            cand = {1'b0, rr_i} + (IdxW + 1)'(k);
            if (cand >= (IdxW + 1)'(NoReq)) begin
                cand = cand - (IdxW + 1)'(NoReq);
            end
            if (!valid_o && reqExt[cand[IdxW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// N-master to 1-slave APB4 arbiter with round-robin grant, locked until the slave completes.
// Losing masters are stalled simply by never seeing pready.
module apb_arbiter #(
    parameter int unsigned NoMasters = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned StrbWidth = (DataWidth + 7) / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NoMasters*AddrWidth-1:0] mst_paddr_i,
    input  logic [NoMasters*3-1:0]         mst_pprot_i,
    input  logic [NoMasters-1:0]           mst_psel_i,
    input  logic [NoMasters-1:0]           mst_penable_i,
    input  logic [NoMasters-1:0]           mst_pwrite_i,
    input  logic [NoMasters*DataWidth-1:0] mst_pwdata_i,
    input  logic [NoMasters*StrbWidth-1:0] mst_pstrb_i,
    output logic [NoMasters-1:0]           mst_pready_o,
    output logic [NoMasters*DataWidth-1:0] mst_prdata_o,
    output logic [NoMasters-1:0]           mst_pslverr_o,
    output logic [AddrWidth-1:0]           slv_paddr_o,
    output logic [2:0]                     slv_pprot_o,
    output logic                           slv_psel_o,
    output logic                           slv_penable_o,
    output logic                           slv_pwrite_o,
    output logic [DataWidth-1:0]           slv_pwdata_o,
    output logic [StrbWidth-1:0]           slv_pstrb_o,
    input  logic                           slv_pready_i,
    input  logic [DataWidth-1:0]           slv_prdata_i,
    input  logic                           slv_pslverr_i
);

    import apb_pkg::*;

    localparam int unsigned IdxW = cf_math_pkg::idx_width(NoMasters);

    arb_state_e           state_q;
    logic [IdxW-1:0]      gnt_q;
    logic [IdxW-1:0]      rr_q;
    logic [IdxW-1:0]      rrNext;
    logic [IdxW-1:0]      pickIdx;
    logic                 pickValid;
    logic                 psel_q;
    logic                 penable_q;
    logic [AddrWidth-1:0] paddr_q, paddr_d;
    prot_t                pprot_q, pprot_d;
    logic                 pwrite_q, pwrite_d;
    logic [DataWidth-1:0] pwdata_q, pwdata_d;
    logic [StrbWidth-1:0] pstrb_q, pstrb_d;

    apb_rr_pick #(
        .NoReq (NoMasters)
    ) u_pick (
        .req_i   (mst_psel_i),
        .rr_i    (rr_q),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_comb begin
        if (gnt_q == IdxW'(NoMasters - 1)) begin
            rrNext = '0;
        end else begin
            rrNext = gnt_q + 1'b1;
        end
    end

    always_comb begin
        paddr_d  = '0;
        pprot_d  = '0;
        pwrite_d = 1'b0;
        pwdata_d = '0;
        pstrb_d  = '0;
        for (int unsigned i = 0; i < NoMasters; i++) begin
            if (pickIdx == IdxW'(i)) begin
                paddr_d  = mst_paddr_i[i*AddrWidth +: AddrWidth];
                pprot_d  = mst_pprot_i[i*3 +: 3];
                pwrite_d = mst_pwrite_i[i];
                pwdata_d = mst_pwdata_i[i*DataWidth +: DataWidth];
                pstrb_d  = mst_pstrb_i[i*StrbWidth +: StrbWidth];
            end
        end
    end

    // Payload is captured once in IDLE and then frozen through SETUP and ACCESS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pickValid) begin
                        state_q   <= ARB_SETUP;
                        gnt_q     <= pickIdx;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= paddr_d;
                        pprot_q   <= pprot_d;
                        pwrite_q  <= pwrite_d;
                        pwdata_q  <= pwdata_d;
                        pstrb_q   <= pstrb_d;
                    end
                end
                ARB_SETUP: begin
                    state_q   <= ARB_ACCESS;
                    penable_q <= 1'b1;
                end
                ARB_ACCESS: begin
                    if (slv_pready_i) begin
                        state_q   <= ARB_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rr_q      <= rrNext;
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    // A master that already dropped psel, or a cycle under reset, gets no completion.
    always_comb begin
        mst_pready_o  = '0;
        mst_prdata_o  = '0;
        mst_pslverr_o = '0;
        if ((state_q == ARB_ACCESS) && slv_pready_i && !rst_i) begin
            for (int unsigned i = 0; i < NoMasters; i++) begin
                if ((gnt_q == IdxW'(i)) && mst_psel_i[i]) begin
                    mst_pready_o[i]                         = 1'b1;
                    mst_prdata_o[i*DataWidth +: DataWidth]  = slv_prdata_i;
                    mst_pslverr_o[i]                        = slv_pslverr_i;
                end
            end
        end
    end

    assign slv_paddr_o   = paddr_q;
    assign slv_pprot_o   = pprot_q;
    assign slv_psel_o    = psel_q;
    assign slv_penable_o = penable_q;
    assign slv_pwrite_o  = pwrite_q;
    assign slv_pwdata_o  = pwdata_q;
    assign slv_pstrb_o   = pstrb_q;

    apbGrantedPselHeld: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != ARB_IDLE) |-> mst_psel_i[gnt_q]);

    apbAccessPenable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_ACCESS) |-> mst_penable_i[gnt_q]);

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: two-, three- and one-master instances on a shared clock/reset.
module tb_apb_arbiter;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [63:0] m2Addr;
    logic [5:0]  m2Prot;
    logic [1:0]  m2Sel, m2En, m2Write;
    logic [63:0] m2Wdata;
    logic [7:0]  m2Strb;
    logic [1:0]  m2Ready, m2Err;
    logic [63:0] m2Rdata;
    logic [31:0] s2Addr, s2Wdata, s2Rdata;
    logic [2:0]  s2Prot;
    logic        s2Sel, s2En, s2Write, s2Ready, s2Err;
    logic [3:0]  s2Strb;

    logic [95:0] m3Addr, m3Wdata, m3Rdata;
    logic [8:0]  m3Prot;
    logic [2:0]  m3Sel, m3En, m3Write, m3Ready, m3Err;
    logic [11:0] m3Strb;
    logic [31:0] s3Addr, s3Wdata, s3Rdata;
    logic [2:0]  s3Prot;
    logic        s3Sel, s3En, s3Write, s3Ready, s3Err;
    logic [3:0]  s3Strb;

    logic [31:0] m1Addr, m1Wdata, m1Rdata;
    logic [2:0]  m1Prot;
    logic        m1Sel, m1En, m1Write, m1Ready, m1Err;
    logic [3:0]  m1Strb;
    logic [31:0] s1Addr, s1Wdata, s1Rdata;
    logic [2:0]  s1Prot;
    logic        s1Sel, s1En, s1Write, s1Ready, s1Err;
    logic [3:0]  s1Strb;

    apb_arbiter #(.NoMasters(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .mst_paddr_i(m2Addr), .mst_pprot_i(m2Prot), .mst_psel_i(m2Sel),
        .mst_penable_i(m2En), .mst_pwrite_i(m2Write), .mst_pwdata_i(m2Wdata),
        .mst_pstrb_i(m2Strb), .mst_pready_o(m2Ready), .mst_prdata_o(m2Rdata),
        .mst_pslverr_o(m2Err), .slv_paddr_o(s2Addr), .slv_pprot_o(s2Prot),
        .slv_psel_o(s2Sel), .slv_penable_o(s2En), .slv_pwrite_o(s2Write),
        .slv_pwdata_o(s2Wdata), .slv_pstrb_o(s2Strb), .slv_pready_i(s2Ready),
        .slv_prdata_i(s2Rdata), .slv_pslverr_i(s2Err)
    );

    apb_arbiter #(.NoMasters(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .mst_paddr_i(m3Addr), .mst_pprot_i(m3Prot), .mst_psel_i(m3Sel),
        .mst_penable_i(m3En), .mst_pwrite_i(m3Write), .mst_pwdata_i(m3Wdata),
        .mst_pstrb_i(m3Strb), .mst_pready_o(m3Ready), .mst_prdata_o(m3Rdata),
        .mst_pslverr_o(m3Err), .slv_paddr_o(s3Addr), .slv_pprot_o(s3Prot),
        .slv_psel_o(s3Sel), .slv_penable_o(s3En), .slv_pwrite_o(s3Write),
        .slv_pwdata_o(s3Wdata), .slv_pstrb_o(s3Strb), .slv_pready_i(s3Ready),
        .slv_prdata_i(s3Rdata), .slv_pslverr_i(s3Err)
    );

    apb_arbiter #(.NoMasters(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .mst_paddr_i(m1Addr), .mst_pprot_i(m1Prot), .mst_psel_i(m1Sel),
        .mst_penable_i(m1En), .mst_pwrite_i(m1Write), .mst_pwdata_i(m1Wdata),
        .mst_pstrb_i(m1Strb), .mst_pready_o(m1Ready), .mst_prdata_o(m1Rdata),
        .mst_pslverr_o(m1Err), .slv_paddr_o(s1Addr), .slv_pprot_o(s1Prot),
        .slv_psel_o(s1Sel), .slv_penable_o(s1En), .slv_pwrite_o(s1Write),
        .slv_pwdata_o(s1Wdata), .slv_pstrb_o(s1Strb), .slv_pready_i(s1Ready),
        .slv_prdata_i(s1Rdata), .slv_pslverr_i(s1Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic sel, input logic en, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        m2Sel[idx]              = sel;
        m2En[idx]               = en;
        m2Write[idx]            = wr;
        m2Addr[idx*32 +: 32]    = addr;
        m2Wdata[idx*32 +: 32]   = data;
        m2Strb[idx*4 +: 4]      = strb;
    endtask

    function automatic int oneHotIdx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    initial begin
        int got;
        int waited;

        rst = 1'b1;
        m2Addr = '0; m2Prot = 6'b101_010; m2Sel = '0; m2En = '0; m2Write = '0;
        m2Wdata = '0; m2Strb = '0; s2Ready = 1'b0; s2Rdata = '0; s2Err = 1'b0;
        m3Addr = '0; m3Prot = '0; m3Sel = '0; m3En = '0; m3Write = '0;
        m3Wdata = '0; m3Strb = '0; s3Ready = 1'b0; s3Rdata = '0; s3Err = 1'b0;
        m1Addr = '0; m1Prot = '0; m1Sel = 1'b0; m1En = 1'b0; m1Write = 1'b0;
        m1Wdata = '0; m1Strb = '0; s1Ready = 1'b0; s1Rdata = '0; s1Err = 1'b0;
        repeat (2) tick();

        checkOutput("rst_psel", s2Sel, 0);
        checkOutput("rst_penable", s2En, 0);
        checkOutput("rst_pready", m2Ready, 0);
        checkOutput("rst_prdata", m2Rdata, 0);
        checkOutput("rst_pslverr", m2Err, 0);
        checkOutput("rst_paddr", s2Addr, 0);
        checkOutput("rst_rr", dut2.rr_q, 0);
        checkOutput("rst_psel_n3", s3Sel, 0);
        checkOutput("rst_psel_n1", s1Sel, 0);

        // Single master write, slave ready on the first ACCESS cycle.
        rst = 1'b0;
        s2Ready = 1'b1;
        applyStimulus(0, 1, 0, 1, 32'h10, 32'hCAFE, 4'hF);
        tick(); #1;
        checkOutput("wr_setup_psel", s2Sel, 1);
        checkOutput("wr_setup_penable", s2En, 0);
        checkOutput("wr_setup_paddr", s2Addr, 32'h10);
        checkOutput("wr_setup_pwdata", s2Wdata, 32'hCAFE);
        checkOutput("wr_setup_pstrb", s2Strb, 4'hF);
        checkOutput("wr_setup_pwrite", s2Write, 1);
        checkOutput("wr_setup_pprot", s2Prot, 3'b010);
        checkOutput("wr_setup_pready", m2Ready, 0);
        m2En[0] = 1'b1;
        tick(); #1;
        checkOutput("wr_access_psel", s2Sel, 1);
        checkOutput("wr_access_penable", s2En, 1);
        checkOutput("wr_access_pready", m2Ready, 2'b01);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("wr_done_rr", dut2.rr_q, 1);
        checkOutput("wr_done_psel", s2Sel, 0);
        checkOutput("wr_done_pready", m2Ready, 0);

        // Contention: both masters read from rr_q = 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("cont_rr_reset", dut2.rr_q, 0);
        applyStimulus(0, 1, 0, 0, 32'h100, 32'h0, 4'h0);
        applyStimulus(1, 1, 0, 0, 32'h200, 32'h0, 4'h0);
        s2Rdata = 32'h11;
        tick(); #1;
        checkOutput("cont_first_paddr", s2Addr, 32'h100);
        checkOutput("cont_first_pwrite", s2Write, 0);
        m2En = 2'b11;
        tick(); #1;
        checkOutput("cont_first_pready", m2Ready, 2'b01);
        checkOutput("cont_first_prdata", m2Rdata, 64'h0000_0000_0000_0011);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        s2Rdata = 32'h22;
        #1;
        checkOutput("cont_gap_pready", m2Ready, 0);
        tick(); #1;
        checkOutput("cont_second_paddr", s2Addr, 32'h200);
        tick(); #1;
        checkOutput("cont_second_pready", m2Ready, 2'b10);
        checkOutput("cont_second_prdata", m2Rdata, 64'h0000_0022_0000_0000);
        tick();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("cont_done_rr", dut2.rr_q, 0);

        // Wait states and error response to master 1 while master 0 is stalled.
        s2Ready = 1'b0;
        s2Err = 1'b0;
        applyStimulus(1, 1, 0, 1, 32'h300, 32'hDEAD_BEEF, 4'h3);
        tick();
        m2En[1] = 1'b1;
        applyStimulus(0, 1, 0, 0, 32'h400, 32'h0, 4'h0);
        #1;
        checkOutput("ws_setup_paddr", s2Addr, 32'h300);
        tick();
        m2En[0] = 1'b1;
        for (int w = 0; w < 4; w++) begin
            #1;
            checkOutput("ws_hold_penable", s2En, 1);
            checkOutput("ws_hold_paddr", s2Addr, 32'h300);
            checkOutput("ws_hold_pwdata", s2Wdata, 32'hDEAD_BEEF);
            checkOutput("ws_hold_pstrb", s2Strb, 4'h3);
            checkOutput("ws_hold_pready", m2Ready, 0);
            tick();
        end
        s2Ready = 1'b1;
        s2Err = 1'b1;
        #1;
        checkOutput("ws_err_pready", m2Ready, 2'b10);
        checkOutput("ws_err_pslverr", m2Err, 2'b10);
        checkOutput("ws_err_paddr", s2Addr, 32'h300);
        tick();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        s2Err = 1'b0;
        s2Rdata = 32'h44;
        #1;
        checkOutput("ws_after_pready", m2Ready, 0);
        checkOutput("ws_after_pslverr", m2Err, 0);
        tick(); #1;
        checkOutput("ws_next_paddr", s2Addr, 32'h400);
        tick(); #1;
        checkOutput("ws_next_pready", m2Ready, 2'b01);
        checkOutput("ws_next_pslverr", m2Err, 0);
        checkOutput("ws_next_prdata", m2Rdata, 64'h0000_0000_0000_0044);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("ws_done_rr", dut2.rr_q, 1);

        // Reset asserted while the slave is in ACCESS.
        s2Ready = 1'b0;
        applyStimulus(0, 1, 0, 1, 32'h500, 32'h5, 4'hF);
        tick();
        m2En[0] = 1'b1;
        tick();
        rst = 1'b1;
        s2Ready = 1'b1;
        #1;
        checkOutput("mid_rst_access_penable", s2En, 1);
        checkOutput("mid_rst_pready_gated", m2Ready, 0);
        tick();
        checkOutput("mid_rst_psel", s2Sel, 0);
        checkOutput("mid_rst_penable", s2En, 0);
        checkOutput("mid_rst_pready", m2Ready, 0);
        checkOutput("mid_rst_rr", dut2.rr_q, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);

        // Fairness with three masters holding psel for six transfers.
        for (int i = 0; i < 3; i++) begin
            m3Addr[i*32 +: 32] = 32'h1000 + 32'(i);
        end
        m3Sel = 3'b111;
        s3Ready = 1'b1;
        s3Rdata = 32'hA5;
        tick();
        m3En = 3'b111;
        for (int k = 0; k < 6; k++) begin
            got = -1;
            waited = 0;
            while (got < 0 && waited < 10) begin
                tick(); #1;
                waited++;
                if (|m3Ready) got = oneHotIdx(m3Ready);
            end
            if (got < 0) begin
                checkOutput("rr3_timeout", 0, 1);
            end else begin
                checkOutput("rr3_order", 64'(got), 64'(k % 3));
                checkOutput("rr3_paddr", s3Addr, 32'h1000 + 32'(k % 3));
                if (k > 0) checkOutput("rr3_gap", 64'(waited), 3);
            end
        end
        tick();
        m3Sel = '0;
        m3En = '0;

        // Single-master instance: back-to-back reads.
        m1Addr = 32'h20;
        m1Sel = 1'b1;
        s1Ready = 1'b1;
        s1Rdata = 32'h77;
        tick();
        m1En = 1'b1;
        for (int k = 0; k < 3; k++) begin
            got = -1;
            waited = 0;
            while (got < 0 && waited < 10) begin
                tick(); #1;
                waited++;
                checkOutput("n1_no_x", 64'($isunknown({m1Ready, m1Rdata, m1Err, s1Addr, s1Prot,
                            s1Sel, s1En, s1Write, s1Wdata, s1Strb})), 0);
                if (m1Ready) got = 0;
            end
            if (got < 0) begin
                checkOutput("n1_timeout", 0, 1);
            end else begin
                checkOutput("n1_prdata", m1Rdata, 32'h77 + 32'(k));
                if (k > 0) checkOutput("n1_gap", 64'(waited), 3);
                s1Rdata = 32'h77 + 32'(k + 1);
            end
        end
        tick();
        m1Sel = 1'b0;
        m1En = 1'b0;
        checkOutput("n1_rr", dut1.rr_q, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
